// File: rtl/store_queue.sv
// Store queue: buffers committed stores and drains them oldest-first to the D-cache,
// with a combinational youngest-first forwarding lookup for loads.
module store_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr_valid,
  input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  output logic                      o_wrote,
  input  logic                      i_fwd_addr_valid,
  input  logic [ADDR_WIDTH-1:0]     i_fwd_addr,
  output logic                      o_fwd_data_valid,
  output logic [DATA_WIDTH-1:0]     o_fwd_data,
  output logic                      o_dc_valid,
  output logic [ADDR_WIDTH-1:0]     o_dc_addr,
  output logic [DATA_WIDTH-1:0]     o_dc_data,
  input  logic                      i_dc_done,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [0:0]       state;
  logic [0:0]       state_next;
  logic             enq;
  logic             deq;
  logic             fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [IDX_W-1:0] slot;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign o_count = tail - head;
  assign o_empty = (head == tail);
  assign o_full  = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

  assign o_wrote = rst_n && i_wr_valid && !o_full;
  assign enq     = o_wrote;
  assign deq     = (state == REQ) && i_dc_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      state <= IDLE;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      state <= state_next;
    end
  end

  // Entry storage needs no reset: only slots between head and tail are ever observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_idx] <= i_wr_addr;
      data_mem[tail_idx] <= i_wr_data;
    end
  end

  // Entering REQ on the enqueue itself gives the one-cycle enqueue-to-request latency.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!o_empty || enq) state_next = REQ;
      REQ:  if (deq && (o_count == PTR_W'(1)) && !enq) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_dc_valid = (state == REQ);
  assign o_dc_addr  = o_dc_valid ? addr_mem[head_idx] : '0;
  assign o_dc_data  = o_dc_valid ? data_mem[head_idx] : '0;

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_idx + IDX_W'(k);
      if ((PTR_W'(k) < o_count) && (addr_mem[slot] == i_fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[slot];
      end
    end
  end

  assign o_fwd_data_valid = rst_n && i_fwd_addr_valid && fwd_hit;
  assign o_fwd_data       = o_fwd_data_valid ? fwd_data : '0;

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_store_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wrote;
  logic        fwd_valid;
  logic [31:0] fwd_addr;
  logic        fwd_data_valid;
  logic [31:0] fwd_data;
  logic        dc_valid;
  logic [31:0] dc_addr;
  logic [31:0] dc_data;
  logic        dc_done;
  logic [CW-1:0] count;
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_wr_valid       (wr_valid),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .o_wrote          (wrote),
    .i_fwd_addr_valid (fwd_valid),
    .i_fwd_addr       (fwd_addr),
    .o_fwd_data_valid (fwd_data_valid),
    .o_fwd_data       (fwd_data),
    .o_dc_valid       (dc_valid),
    .o_dc_addr        (dc_addr),
    .o_dc_data        (dc_data),
    .i_dc_done        (dc_done),
    .o_count          (count),
    .o_full           (full),
    .o_empty          (empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t q[$];
  int     vectors     = 0;
  int     miscompares = 0;
  bit     check_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_wrote();
    return rst_n && wr_valid && (q.size() < DEPTH);
  endfunction

  // Returns {hit, data}: youngest pending store to the same address wins.
  function automatic logic [32:0] model_fwd();
    if (!rst_n || !fwd_valid) return 33'h0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr == fwd_addr) return {1'b1, q[i].data};
    return 33'h0;
  endfunction

  always @(posedge clk) begin
    bit en;
    bit de;
    if (!rst_n) begin
      q.delete();
    end else begin
      en = model_wrote();
      de = (q.size() > 0) && dc_done;
      if (de) void'(q.pop_front());
      if (en) q.push_back('{wr_addr, wr_data});
    end
  end

  // The drain request is outstanding exactly while the queue holds anything.
  always @(negedge clk) begin
    logic [32:0] f;
    if (check_en) begin
      f = model_fwd();
      check("wrote",    wrote,          model_wrote());
      check("fwd_hit",  fwd_data_valid, f[32]);
      check("fwd_data", fwd_data,       f[31:0]);
      check("dc_valid", dc_valid,       q.size() > 0);
      check("dc_addr",  dc_addr,        (q.size() > 0) ? q[0].addr : 32'h0);
      check("dc_data",  dc_data,        (q.size() > 0) ? q[0].data : 32'h0);
      check("count",    count,          q.size());
      check("full",     full,           q.size() == DEPTH);
      check("empty",    empty,          q.size() == 0);
    end
  end

  task automatic apply_stimulus(input bit rst, input bit wv, input logic [31:0] wa,
                                input logic [31:0] wd, input bit fv, input logic [31:0] fa,
                                input bit done);
    rst_n     = rst;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    fwd_valid = fv;
    fwd_addr  = fa;
    dc_done   = done;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    fwd_valid = 1'b0; fwd_addr = '0; dc_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_en = 1'b1;

    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dc_valid", dc_valid, 0);
    check("rst_dc_addr", dc_addr, 0);
    next_cycle();

    // Fill to full with the cache stalled, then a fifth store must bounce.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1, 32'h100 + 32'(4 * i), 32'hA + 32'(i), 0, 0, 0);
      check("fill_wrote", wrote, 1);
      next_cycle();
    end
    apply_stimulus(1, 1, 32'h110, 32'hE, 0, 0, 0);
    check("full_flag", full, 1);
    check("full_count", count, 4);
    check("full_reject", wrote, 0);
    next_cycle();

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0, 1);
      check("drain_valid", dc_valid, 1);
      check("drain_addr", dc_addr, 32'h100 + 32'(4 * i));
      next_cycle();
    end
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    check("drained_valid", dc_valid, 0);
    check("drained_empty", empty, 1);
    next_cycle();

    // Youngest-first forwarding.
    apply_stimulus(1, 1, 32'h200, 32'h1, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 1, 32'h200, 32'h2, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 1, 32'h200, 0);
    check("fwd_young_hit", fwd_data_valid, 1);
    check("fwd_young_data", fwd_data, 32'h2);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 1, 32'h204, 0);
    check("fwd_miss_hit", fwd_data_valid, 0);
    check("fwd_miss_data", fwd_data, 0);
    next_cycle();

    // Steady state: enqueue and dequeue together across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1, 1, 32'h400 + 32'(4 * i), 32'h50 + 32'(i), 0, 0, 1);
      check("steady_wrote", wrote, 1);
      check("steady_count", count, 2);
      check("steady_data", dc_data, (i == 0) ? 32'h1 : (i == 1) ? 32'h2 : 32'h50 + 32'(i - 2));
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0, 1);
      next_cycle();
    end

    // A store in flight this cycle is invisible to the lookup until registered.
    apply_stimulus(1, 1, 32'h300, 32'h7, 1, 32'h300, 0);
    check("same_cycle_hit", fwd_data_valid, 0);
    check("same_cycle_wrote", wrote, 1);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 1, 32'h300, 0);
    check("next_cycle_hit", fwd_data_valid, 1);
    check("next_cycle_data", fwd_data, 32'h7);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0, 1);
    next_cycle();

    // Reset while a drain request is outstanding.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 1, 32'h500 + 32'(4 * i), 32'h60 + 32'(i), 0, 0, 0);
      next_cycle();
    end
    apply_stimulus(0, 0, 0, 0, 1, 32'h500, 0);
    check("rst_mid_valid_before", dc_valid, 1);
    check("rst_mid_fwd_gated", fwd_data_valid, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0, 1);
      check("rst_mid_valid_after", dc_valid, 0);
      check("rst_mid_count", count, 0);
      next_cycle();
    end

    // Randomized traffic with a small address pool so forwarding hits are common.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] wa;
      logic [31:0] fa;
      wa = (32'($urandom_range(0, 7)) << 2) | (($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'h0);
      fa = (32'($urandom_range(0, 7)) << 2) | (($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'h0);
      apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), wa, $urandom(),
                     ($urandom_range(0, 1) == 1), fa, ($urandom_range(0, 2) != 0));
      next_cycle();
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0, 1);
      next_cycle();
    end
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    check("final_empty", empty, 1);
    next_cycle();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_queue.md
# store_queue

Buffers committed stores from the load/store execution unit and drains them, oldest first, into the D-cache as write requests. It sits directly downstream of the load/store execution unit. It accepts the unit's store (valid, addr, data) and returns a same-cycle accept. It also answers the unit's load-forwarding lookup combinationally, so a load that hits a pending store completes without touching the cache.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, store data width (full-word stores only)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- i_wr_valid  in  1  store offered by execution unit
- i_wr_addr  in  ADDR_WIDTH  store address
- i_wr_data  in  DATA_WIDTH  store data
- o_wrote  out  1  store accepted this cycle (combinational)
- i_fwd_addr_valid  in  1  load lookup request
- i_fwd_addr  in  ADDR_WIDTH  load address
- o_fwd_data_valid  out  1  lookup hit (combinational)
- o_fwd_data  out  DATA_WIDTH  data of youngest matching entry; 0 on miss
- o_dc_valid  out  1  write request to D-cache
- o_dc_addr  out  ADDR_WIDTH  head entry address
- o_dc_data  out  DATA_WIDTH  head entry data
- i_dc_done  in  1  D-cache completed the presented write
- o_count  out  $clog2(DEPTH)+1  occupied entries
- o_full, o_empty  out  1  occupancy flags

## Operation
- Storage is a circular buffer: DEPTH × {addr, data}.
- head and tail pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty: head == tail.
  - full: index bits are equal and wrap bits differ.
- o_count = tail − head, modulo 2^($clog2(DEPTH)+1).
- Enqueue:
  - o_wrote = i_wr_valid && !o_full.
  - On the edge, the entry is written at tail[idx] and tail increments.
  - Full blocks enqueue even when a dequeue occurs in the same cycle.
- Drain FSM has two states, IDLE and REQ:
  - IDLE: o_dc_valid = 0. Go to REQ when !o_empty.
  - REQ: o_dc_valid = 1. o_dc_addr and o_dc_data are the head entry and stay stable until i_dc_done.
  - On i_dc_done, head increments. Go to IDLE if the queue becomes empty (count was 1 with no enqueue that cycle); otherwise stay in REQ and present the new head next cycle.
  - i_dc_done in IDLE is ignored.
- Simultaneous enqueue and dequeue: both pointers advance and the count is unchanged.
- Forwarding:
  - When i_fwd_addr_valid is high, compare i_fwd_addr against every occupied entry using the full ADDR_WIDTH.
  - Priority is youngest first: the entry nearest tail−1 wins.
  - The search covers registered entries only. A store being enqueued in the same cycle is not visible.
  - The head entry stays visible through the cycle its i_dc_done arrives.
  - When i_fwd_addr_valid is low, o_fwd_data_valid = 0 and o_fwd_data = 0.
- Stores are never reordered or merged. Every accepted store produces exactly one D-cache write, in acceptance order.

## Timing
- Reset (rst_n low at an edge):
  - head = tail = 0 and FSM = IDLE.
  - Outputs after reset: o_dc_valid = 0, o_dc_addr = 0, o_dc_data = 0, o_count = 0, o_empty = 1, o_full = 0.
  - o_wrote and o_fwd_data_valid are 0 while rst_n is low.
- Reset mid-drain drops all entries. o_dc_valid is 0 from the first cycle after the reset edge.
- o_wrote, o_fwd_data_valid and o_fwd_data are combinational, with same-cycle response.
- A store accepted at edge N raises o_dc_valid in cycle N+1 if the queue was empty. Minimum enqueue-to-request latency is 1 cycle.
- Drain throughput: one store per cycle while i_dc_done is held high.
- o_count, o_full and o_empty are valid in the cycle after the pointer update. They are derived combinationally from the registered pointers.
- Pointer wrap: after DEPTH enqueues, the index returns to 0 and the wrap bit toggles.

## Test plan
- Reset, then DEPTH=4. Offer stores (0x100,0xA),(0x104,0xB),(0x108,0xC),(0x10C,0xD) with i_dc_done=0. Required: o_wrote=1 for each, then o_full=1, o_count=4. A 5th store (0x110,0xE) gets o_wrote=0.
- From that full state, pulse i_dc_done each cycle. Required: o_dc_addr sequence is 0x100, 0x104, 0x108, 0x10C, then o_dc_valid=0 and o_empty=1.
- Enqueue (0x200,0x1) then (0x200,0x2) with the cache stalled, then look up 0x200. Required: o_fwd_data_valid=1, o_fwd_data=0x2. Lookup 0x204: o_fwd_data_valid=0, o_fwd_data=0.
- With count=2 and i_dc_done=1, offer a store in the same cycle. Required: o_wrote=1 and count stays 2. Run 10 such cycles to exercise pointer wrap; required: FIFO order is preserved.
- Same-cycle visibility: offer store (0x300,0x7) and a lookup of 0x300 in the same cycle on an empty queue. Required: o_fwd_data_valid=0. One cycle later, required: hit with data 0x7.
- Load 3 entries, hold rst_n=0 for one edge while o_dc_valid=1. Required: the next cycle shows o_dc_valid=0, o_count=0, and no further D-cache writes.
